ram_cmd_sequencer: RTL

- Upstream command stage for the SRAM path: turns a UART byte stream into read/write transactions on the level-based ram_controller handshake (en/re/we in, done out).
- Returns read data as two bytes to the UART transmitter.
- Sits between uart_rx/uart_tx and ram_controller; the only master of ram_controller.

---
 rtl/ram_cmd_sequencer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ram_cmd_sequencer.sv
// ram_cmd_sequencer: decodes a UART byte stream into read/write transactions on
// the level-based ram_controller handshake (en/re/we out, done in) and returns
// read data as two bytes to uart_tx.
// Optional build macro RAM_SEQ_WRITE_ACK_EN: when defined, a completed write
// sends one 'K' (8'h4B) acknowledge byte; when undefined, writes finish silently.
module ram_cmd_sequencer #(
    parameter logic [7:0] CMD_WRITE   = 8'h57,
    parameter logic [7:0] CMD_READ    = 8'h52,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        ram_en,
    output logic        ram_re,
    output logic        ram_we,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        ram_done,
    output logic        busy,
    output logic        err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR2,
        ADDR1,
        ADDR0,
        DAT1,
        DAT0,
        ISSUE,
        RELEASE,
        TX_HI,
`ifdef RAM_SEQ_WRITE_ACK_EN
        TX_LO,
        TX_ACK
`else
        TX_LO
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_done_meta;
    logic               r_done_s;
    logic               r_is_wr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_tx_gap;
    logic [15:0]        r_rdata;
    logic [17:0]        r_addr;
    logic [15:0]        r_wdata;
    logic [7:0]         r_tx_data;
    logic               r_tx_start;
    logic               r_ram_en;
    logic               r_ram_re;
    logic               r_ram_we;
    logic               r_busy;
    logic               r_err;

    logic               w_err;
    logic               w_fire;
    logic               w_cap;
    logic [7:0]         w_tx_byte;
    logic               w_timeout;
    logic               w_wait_state;
    logic               w_ack_ok;

    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign ram_en    = r_ram_en;
    assign ram_re    = r_ram_re;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign busy      = r_busy;
    assign err       = r_err;

    // A new tx byte may go out only once the previous strobe has had a cycle
    // to raise tx_busy and the transmitter reports idle.
    assign w_ack_ok     = !tx_busy && !r_tx_gap;
    assign w_wait_state = (r_state == ISSUE) || (r_state == RELEASE);
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the per-cycle events (error, tx fire, rdata capture).
    always_comb begin
        w_next    = r_state;
        w_err     = 1'b0;
        w_fire    = 1'b0;
        w_cap     = 1'b0;
        w_tx_byte = 8'h00;
        unique case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
                        w_next = ADDR2;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ADDR2:   if (rx_valid) w_next = ADDR1;
            ADDR1:   if (rx_valid) w_next = ADDR0;
            ADDR0:   if (rx_valid) w_next = r_is_wr ? DAT1 : ISSUE;
            DAT1:    if (rx_valid) w_next = DAT0;
            DAT0:    if (rx_valid) w_next = ISSUE;
            ISSUE: begin
                if (r_done_s) begin
                    w_cap  = !r_is_wr;
                    w_next = RELEASE;
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = IDLE;
                end
            end
            RELEASE: begin
                if (!r_done_s) begin
`ifdef RAM_SEQ_WRITE_ACK_EN
                    w_next = r_is_wr ? TX_ACK : TX_HI;
`else
                    w_next = r_is_wr ? IDLE : TX_HI;
`endif
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = IDLE;
                end
            end
            TX_HI: begin
                if (w_ack_ok) begin
                    w_fire    = 1'b1;
                    w_tx_byte = r_rdata[15:8];
                    w_next    = TX_LO;
                end
            end
            TX_LO: begin
                if (w_ack_ok) begin
                    w_fire    = 1'b1;
                    w_tx_byte = r_rdata[7:0];
                    w_next    = IDLE;
                end
            end
`ifdef RAM_SEQ_WRITE_ACK_EN
            TX_ACK: begin
                if (w_ack_ok) begin
                    w_fire    = 1'b1;
                    w_tx_byte = 8'h4B;
                    w_next    = IDLE;
                end
            end
`endif
            default: w_next = IDLE;
        endcase
        // Bytes arriving while a transaction is in flight are dropped as overrun;
        // a coincident timeout shares the same single err pulse.
        if (rx_valid && (w_wait_state || (r_state == TX_HI) || (r_state == TX_LO)
`ifdef RAM_SEQ_WRITE_ACK_EN
                         || (r_state == TX_ACK)
`endif
                         )) begin
            w_err = 1'b1;
        end
    end

    // Control registers: synchronizer, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_meta <= 1'b0;
            r_done_s    <= 1'b0;
            r_cnt       <= '0;
            r_tx_gap    <= 1'b0;
            r_tx_start  <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_re    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done_meta <= ram_done;
            r_done_s    <= r_done_meta;
            if ((w_next != r_state) || !w_wait_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_tx_gap   <= w_fire;
            r_tx_start <= w_fire;
            r_ram_en   <= (w_next == ISSUE) || (w_next == RELEASE);
            r_ram_re   <= (w_next == ISSUE) && !r_is_wr;
            r_ram_we   <= (w_next == ISSUE) && r_is_wr;
            r_busy     <= (w_next != IDLE);
            r_err      <= w_err;
        end
    end

    // Frame fields, read-data capture and the tx byte register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_wr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_tx_data <= '0;
        end else begin
            if (rx_valid) begin
                unique case (r_state)
                    IDLE:    if (w_next == ADDR2) r_is_wr <= (rx_data == CMD_WRITE);
                    ADDR2:   r_addr[17:16]  <= rx_data[1:0];
                    ADDR1:   r_addr[15:8]   <= rx_data;
                    ADDR0:   r_addr[7:0]    <= rx_data;
                    DAT1:    r_wdata[15:8]  <= rx_data;
                    DAT0:    r_wdata[7:0]   <= rx_data;
                    default: ;
                endcase
            end
            if (w_cap) begin
                r_rdata <= ram_rdata;
            end
            if (w_fire) begin
                r_tx_data <= w_tx_byte;
            end
        end
    end

endmodule
